recv_protocol: RTL and testbench

Serial-to-parallel receiver for the single-wire link driven by the transmitter's protocol engine. It samples `S_Data` once per clock and detects a start bit. It shifts in a fixed-width payload, checks the stop bit and presents the word on a parallel port held by a one-entry output register. It sits at the router input port, between the serial link and the flit buffer. The buffer consumes words through a valid/ack handshake.

---
 rtl/rx_pkg.sv | 18 +
 rtl/rx_shift_reg.sv | 35 +++
 rtl/recv_protocol.sv | 104 ++++++++++
 tb/tb_recv_protocol.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// rx_pkg: shared constants and FSM state type for the serial frame receiver.
`default_nettype none

package rx_pkg;

  localparam int DATA_W    = 55;
  localparam int CNT_W     = 6;
  localparam int FRAME_LEN = DATA_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/rx_shift_reg.sv
// rx_shift_reg: payload register written one bit at a time at an arbitrary index,
// with synchronous clear and full parallel output.
`default_nettype none

module rx_shift_reg #(
  parameter int WIDTH = rx_pkg::DATA_W,
  parameter int IDX_W = rx_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] idx,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // Per-bit decode keeps indices beyond WIDTH-1 from ever touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (wr_en && (idx == IDX_W'(i))) begin
          q[i] <= din;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/recv_protocol.sv
// recv_protocol: single-wire frame receiver (start 1, DATA_W bits LSB first, stop 0)
// feeding a one-entry valid/ack output register. Macro RX_STOP_CHECK_EN enables the stop-bit check.
`default_nettype none

module recv_protocol #(
  parameter int DATA_W = rx_pkg::DATA_W,
  parameter int CNT_W  = rx_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              S_Data,
  output logic [DATA_W-1:0] RX_Data,
  output logic              RX_Data_Valid,
  input  logic              RX_Ack,
  output logic              Frame_Err,
  output logic              Overrun
);

  import rx_pkg::*;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shift_q;
  logic              shift_clr;
  logic              shift_wr;
  logic              stop_good;

  assign shift_clr = (state == IDLE) && S_Data;
  assign shift_wr  = (state == DATA);

`ifdef RX_STOP_CHECK_EN
  assign stop_good = ~S_Data;
`else
  assign stop_good = 1'b1;
`endif

  rx_shift_reg #(
    .WIDTH (DATA_W),
    .IDX_W (CNT_W)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .clr   (shift_clr),
    .wr_en (shift_wr),
    .idx   (cnt),
    .din   (S_Data),
    .q     (shift_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      RX_Data       <= '0;
      RX_Data_Valid <= 1'b0;
      Frame_Err     <= 1'b0;
      Overrun       <= 1'b0;
    end else begin
      Frame_Err <= 1'b0;
      Overrun   <= 1'b0;
      // A load in STOP below overrides this, giving gapless replace-on-ack.
      if (RX_Data_Valid && RX_Ack) begin
        RX_Data_Valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (S_Data) begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state <= STOP;
          end
        end
        STOP: begin
          state <= IDLE;
          if (stop_good) begin
            if (!RX_Data_Valid || RX_Ack) begin
              RX_Data       <= shift_q;
              RX_Data_Valid <= 1'b1;
            end else begin
              Overrun <= 1'b1;
            end
          end else begin
`ifdef RX_STOP_CHECK_EN
            Frame_Err <= 1'b1;
`else
            Frame_Err <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_recv_protocol.sv
// tb_recv_protocol: directed frames; expected words/pulses queued by stimulus, checked by a monitor.
`default_nettype none

module tb_recv_protocol;

  localparam int DW = 55;
  localparam int K_WORD = 0;
  localparam int K_OVR  = 1;
  localparam int K_FERR = 2;

  typedef struct {
    int            kind;
    logic [DW-1:0] data;
    int            exp_cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          S_Data = 1'b0;
  logic [DW-1:0] RX_Data;
  logic          RX_Data_Valid;
  logic          RX_Ack = 1'b0;
  logic          Frame_Err;
  logic          Overrun;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  logic auto_ack = 1'b0;
  logic man_ack = 1'b0;

  recv_protocol dut (
    .clk           (clk),
    .rst           (rst),
    .S_Data        (S_Data),
    .RX_Data       (RX_Data),
    .RX_Data_Valid (RX_Data_Valid),
    .RX_Ack        (RX_Ack),
    .Frame_Err     (Frame_Err),
    .Overrun       (Overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    RX_Ack = auto_ack ? RX_Data_Valid : man_ack;
  end

  // Monitor
  logic          prev_valid = 1'b0;
  logic          prev_ack = 1'b0;
  logic [DW-1:0] last_data = '0;

  task automatic pop_check(input int kind, input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event, data %h, nothing queued", name, RX_Data);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("FAIL %s: event kind %0d, required kind %0d", name, kind, e.kind);
      end else if (RX_Data !== e.data) begin
        errors++;
        $display("FAIL %s: data %h, required %h", name, RX_Data, e.data);
      end else if (e.exp_cyc >= 0 && cyc != e.exp_cyc) begin
        errors++;
        $display("FAIL %s: seen at cycle %0d, required %0d", name, cyc, e.exp_cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (Overrun === 1'b1) pop_check(K_OVR, "overrun");
      if (Frame_Err === 1'b1) pop_check(K_FERR, "frame_err");
      if (RX_Data_Valid === 1'b1 && (!prev_valid || prev_ack)) begin
        pop_check(K_WORD, "word");
      end else if (RX_Data_Valid === 1'b1) begin
        checks++;
        if (RX_Data !== last_data) begin
          errors++;
          $display("FAIL hold: data %h changed, required %h", RX_Data, last_data);
        end
      end
      prev_valid = (RX_Data_Valid === 1'b1);
      prev_ack   = (RX_Ack === 1'b1) && prev_valid;
      last_data  = RX_Data;
    end
  end

  // Starts at posedge+1; returns at posedge+1 with the line idle, ready for a back-to-back start.
  task automatic send_frame(input logic [DW-1:0] p, input logic stop, input logic ack_at_stop,
                            input int kind, input logic [DW-1:0] exp_data, input logic timed);
    exp_t e;
    e.kind    = kind;
    e.data    = exp_data;
    e.exp_cyc = timed ? cyc + DW + 2 : -1;
    sb.push_back(e);
    S_Data = 1'b1;
    for (int i = 0; i < DW; i++) begin
      @(posedge clk); #1;
      S_Data = p[i];
    end
    @(posedge clk); #1;
    S_Data = stop;
    if (ack_at_stop) man_ack = 1'b1;
    @(posedge clk); #1;
    S_Data  = 1'b0;
    man_ack = 1'b0;
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] pa, pb, pc, pd, pr;
    int bad;
    pa = 55'h2A_AAAA_AAAA_AAAA;
    pb = 55'h12_3456_789A_BCDE;
    pc = 55'h7F_FFFF_FFFF_FFFF;
    pd = 55'h00_0000_0000_0033;
    pr = 55'h15_5A5A_0F0F_F0F0;

    repeat (3) @(posedge clk);
    #1;
    check1("reset_valid", RX_Data_Valid, 1'b0);
    check1("reset_ferr", Frame_Err, 1'b0);
    check1("reset_ovr", Overrun, 1'b0);
    checks++;
    if (RX_Data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0", RX_Data);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Single frame with latency check, then manual ack.
    send_frame(pa, 1'b0, 1'b0, K_WORD, pa, 1'b1);
    bad = 1;
    for (int i = 0; i < 10; i++) begin
      if (RX_Data_Valid === 1'b1) begin
        bad = 0;
        break;
      end
      @(posedge clk); #1;
    end
    check1("first_valid_seen", bad == 0, 1'b1);
    man_ack = 1'b1;
    @(posedge clk); #1;
    man_ack = 1'b0;
    check1("ack_drops_valid", RX_Data_Valid, 1'b0);
    repeat (3) @(posedge clk); #1;

    // Back-to-back frames, auto ack one cycle after valid.
    auto_ack = 1'b1;
    send_frame(55'h1, 1'b0, 1'b0, K_WORD, 55'h1, 1'b0);
    send_frame(55'h40_0000_0000_0000, 1'b0, 1'b0, K_WORD, 55'h40_0000_0000_0000, 1'b0);
    repeat (4) @(posedge clk); #1;
    auto_ack = 1'b0;

    // Overrun, then replace-on-ack at the stop cycle.
    send_frame(pb, 1'b0, 1'b0, K_WORD, pb, 1'b0);
    send_frame(55'h0F, 1'b0, 1'b0, K_OVR, pb, 1'b0);
    send_frame(pc, 1'b0, 1'b1, K_WORD, pc, 1'b0);
    check1("replace_valid", RX_Data_Valid, 1'b1);
    man_ack = 1'b1;
    @(posedge clk); #1;
    man_ack = 1'b0;
    check1("replace_acked", RX_Data_Valid, 1'b0);

    // Bad stop bit.
    auto_ack = 1'b1;
`ifdef RX_STOP_CHECK_EN
    send_frame('0, 1'b1, 1'b0, K_FERR, '0, 1'b0);
    #5;
    check1("ferr_no_valid", RX_Data_Valid, 1'b0);
`else
    send_frame('0, 1'b1, 1'b0, K_WORD, '0, 1'b0);
    check1("nochk_valid", RX_Data_Valid, 1'b1);
`endif
    repeat (4) @(posedge clk); #1;
    auto_ack = 1'b0;

    // Reset mid-frame with an unconsumed word present.
    send_frame(pd, 1'b0, 1'b0, K_WORD, pd, 1'b0);
    S_Data = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      S_Data = pr[i];
    end
    @(posedge clk); #1;
    S_Data = 1'b0;
    rst = 1'b1;
    #1;
    check1("midrst_valid", RX_Data_Valid, 1'b0);
    check1("midrst_ferr", Frame_Err, 1'b0);
    check1("midrst_ovr", Overrun, 1'b0);
    checks++;
    if (RX_Data !== '0) begin
      errors++;
      $display("FAIL midrst_data: got %h, required 0", RX_Data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    auto_ack = 1'b1;
    send_frame(55'h7FF, 1'b0, 1'b0, K_WORD, 55'h7FF, 1'b0);
    repeat (4) @(posedge clk); #1;

    // Idle line.
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (RX_Data_Valid !== 1'b0 || Frame_Err !== 1'b0 || Overrun !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: %0d active cycles, required 0", bad);
    end

    repeat (5) @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events never seen, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
